pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high (`RSTENABLE = 1).
REQ-004 stall  input  6  pipeline stall vector; this block uses only stall[0] (`STOP = 1, `NOSTOP = 0).
REQ-005 branch_flag  input  1  one-cycle redirect request from ID/EX.
REQ-006 branch_target_addr  input  64  redirect target.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  64  request address; equals pc_pc.
REQ-009 imem_gnt  input  1  memory accepts the request in this cycle.
REQ-010 imem_rvalid  input  1  read data valid; one response per granted request.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 pc_pc  output  64  PC presented to pc_id.
REQ-013 pc_instreg_inst  output  32  instruction presented to pc_id; `ZERO_32 when not in HOLD.
REQ-014 stallreq_if  output  1  fetch-not-ready request to the stall controller.

Function
REQ-015 The FSM SHALL have three states: REQ (issue fetch), WAIT (await response) and HOLD (instruction buffered).
REQ-016 In REQ: imem_req = 1 and imem_addr = pc; if imem_gnt = 1, go to WAIT; otherwise stay in REQ.
REQ-017 In WAIT: imem_req = 0; on imem_rvalid with kill = 0, latch imem_rdata into inst_buf and go to HOLD; on imem_rvalid with kill = 1, discard the data, clear kill and go to REQ.
REQ-018 In HOLD: when stall[0] = `NOSTOP, pc <= pc + 4 and go to REQ; when stall[0] = `STOP, keep pc and inst_buf unchanged.
REQ-019 stallreq_if = 1 in REQ and WAIT, and 0 in HOLD.
REQ-020 PC arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-021 Redirect target SHALL be {branch_target_addr[63:2], 2'b00}.
REQ-022 branch_flag in REQ, no grant in that cycle: pc <= target; stay in REQ.
REQ-023 branch_flag in REQ with imem_gnt in the same cycle: pc <= target; kill <= 1; go to WAIT.
REQ-024 branch_flag in WAIT: pc <= target; kill <= 1, unless imem_rvalid occurs in the same cycle, in which case discard the data and go to REQ with kill = 0.
REQ-025 branch_flag in HOLD: pc <= target; discard inst_buf; go to REQ; branch_flag takes priority over the stall[0] advance.
REQ-026 Single outstanding request only; imem_req SHALL NOT be asserted in WAIT.
REQ-027 Throughput with zero-wait memory (gnt in the request cycle, rvalid the next cycle) SHALL be one instruction per 3 cycles.

Reset
REQ-028 While rst = 1, asynchronously: state = REQ, pc = RESET_PC, kill = 0, inst_buf = `ZERO_32.
REQ-029 After reset, imem_req = 1 with imem_addr = RESET_PC; a response to a request granted before reset SHALL be ignored.
REQ-030 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the fetch with no output glitch after deassertion.

Structure
REQ-031 `STOP, `NOSTOP, `RSTENABLE, `ZERO_32, `ZERO_64, `REGBUS, `INSTBUS and the state encodings SHALL live in the shared define file.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Reset release, zero-wait memory, stall = 0: pc_pc sequence 0, 4, 8, one new value every 3 cycles; stallreq_if pattern 1,1,0.
REQ-034 HOLD at pc = 0x10 with stall[0] = 1 for 5 cycles: pc_pc and pc_instreg_inst stay constant; no imem_req is issued.
REQ-035 branch_flag with target 0x203 while in WAIT at pc = 0x8: the stale response is dropped; the next imem_addr is 0x200 and HOLD presents the 0x200 instruction.
REQ-036 branch_flag in the same cycle as imem_rvalid: the data is dropped; REQ is issued at the target on the next cycle.
REQ-037 imem_gnt delayed 4 cycles: imem_req and imem_addr are held stable; stallreq_if = 1 throughout.
REQ-038 PC at 64'hFFFF_FFFF_FFFF_FFFC advances to 0; rst asserted in WAIT gives pc_pc = RESET_PC immediately.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package pc_fetch_pkg;

  // Stall vector bit values
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Reset polarity
  localparam logic RSTENABLE = 1'b1;

  // Bus widths and zero constants
  localparam int unsigned REGBUS  = 64;
  localparam int unsigned INSTBUS = 32;
  localparam logic [INSTBUS-1:0] ZERO_32 = '0;
  localparam logic [REGBUS-1:0]  ZERO_64 = '0;

  // Fetch FSM: REQ issues the fetch, WAIT awaits the response, HOLD buffers the instruction
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Redirect targets are forced to a word boundary
  function automatic logic [REGBUS-1:0] align_target(input logic [REGBUS-1:0] addr);
    return {addr[REGBUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and single-outstanding instruction fetch FSM
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [63:0] branch_target_addr,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc_pc,
  output logic [31:0] pc_instreg_inst,
  output logic        stallreq_if
);

  fetch_state_t state;
  logic [63:0]  pc;
  logic [31:0]  inst_buf;
  logic         kill;
  logic [63:0]  target;

  // Only stall[0] and the word-aligned part of the target matter here
  logic unused;
  assign unused = ^{stall[5:1], branch_target_addr[1:0]};

  assign target = align_target(branch_target_addr);

  // Outputs decode directly from registered state, so they cannot glitch
  assign imem_req        = (state == ST_REQ);
  assign imem_addr       = pc;
  assign pc_pc           = pc;
  assign stallreq_if     = (state != ST_HOLD);
  assign pc_instreg_inst = (state == ST_HOLD) ? inst_buf : ZERO_32;

  // Fetch FSM with redirect handling; kill marks an in-flight response to be dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RSTENABLE) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      inst_buf <= ZERO_32;
    end else begin
      case (state)
        ST_REQ: begin
          if (branch_flag) begin
            pc <= target;
          end
          if (imem_gnt) begin
            // A redirect in the grant cycle makes the granted fetch stale
            kill  <= branch_flag;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (branch_flag) begin
              pc <= target;
            end
            if (kill || branch_flag) begin
              state <= ST_REQ;
            end else begin
              inst_buf <= imem_rdata;
              state    <= ST_HOLD;
            end
          end else if (branch_flag) begin
            pc   <= target;
            kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          // Redirect wins over the sequential advance
          if (branch_flag) begin
            pc    <= target;
            state <= ST_REQ;
          end else if (stall[0] == NOSTOP) begin
            pc    <= pc + 64'd4;
            state <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [63:0] branch_target_addr;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] pc_pc;
  logic [31:0] pc_instreg_inst;
  logic        stallreq_if;

  int checks;
  int errors;

  pc_fetch #(.RESET_PC(64'h0)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .branch_flag        (branch_flag),
    .branch_target_addr (branch_target_addr),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_gnt           (imem_gnt),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .pc_pc              (pc_pc),
    .pc_instreg_inst    (pc_instreg_inst),
    .stallreq_if        (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Instruction word the bench memory returns for an address
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One zero-wait fetch starting in REQ at pc_exp; returns with the DUT in HOLD
  task automatic fetch(input logic [63:0] pc_exp);
    check("req_imem_req", {63'h0, imem_req}, 64'h1);
    check("req_imem_addr", imem_addr, pc_exp);
    check("req_stallreq", {63'h0, stallreq_if}, 64'h1);
    check("req_inst_zero", {32'h0, pc_instreg_inst}, 64'h0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("wait_imem_req", {63'h0, imem_req}, 64'h0);
    check("wait_stallreq", {63'h0, stallreq_if}, 64'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = inst_of(pc_exp);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    check("hold_pc", pc_pc, pc_exp);
    check("hold_inst", {32'h0, pc_instreg_inst}, {32'h0, inst_of(pc_exp)});
    check("hold_stallreq", {63'h0, stallreq_if}, 64'h0);
    check("hold_imem_req", {63'h0, imem_req}, 64'h0);
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    stall              = 6'h0;
    branch_flag        = 1'b0;
    branch_target_addr = 64'h0;
    imem_gnt           = 1'b0;
    imem_rvalid        = 1'b0;
    imem_rdata         = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_pc", pc_pc, 64'h0);
    check("rst_imem_req", {63'h0, imem_req}, 64'h1);
    check("rst_stallreq", {63'h0, stallreq_if}, 64'h1);
    check("rst_inst", {32'h0, pc_instreg_inst}, 64'h0);
    rst = 1'b0;

    // Zero-wait stream: a new PC every three cycles
    fetch(64'h0);
    tick();
    fetch(64'h4);
    tick();
    fetch(64'h8);
    tick();
    fetch(64'hC);
    tick();

    // HOLD at 0x10 under stall[0] for five cycles
    stall = 6'h01;
    fetch(64'h10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pc", pc_pc, 64'h10);
      check("stall_inst", {32'h0, pc_instreg_inst}, {32'h0, inst_of(64'h10)});
      check("stall_no_req", {63'h0, imem_req}, 64'h0);
    end
    // Upper stall bits are ignored
    stall = 6'h3E;
    tick();
    check("stall_hi_adv_pc", pc_pc, 64'h14);
    check("stall_hi_req", {63'h0, imem_req}, 64'h1);
    stall = 6'h0;

    // Grant delayed four cycles: request held stable
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dly_req", {63'h0, imem_req}, 64'h1);
      check("dly_addr", imem_addr, 64'h14);
      check("dly_stallreq", {63'h0, stallreq_if}, 64'h1);
    end
    fetch(64'h14);

    // Redirect in HOLD beats a held stall; target aligned down to 0x8
    stall              = 6'h01;
    branch_flag        = 1'b1;
    branch_target_addr = 64'h9;
    tick();
    branch_flag = 1'b0;
    stall       = 6'h0;
    check("hold_br_pc", pc_pc, 64'h8);
    check("hold_br_req", {63'h0, imem_req}, 64'h1);
    check("hold_br_inst", {32'h0, pc_instreg_inst}, 64'h0);

    // Redirect in WAIT at 0x8 to 0x203: stale response dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt           = 1'b0;
    branch_flag        = 1'b1;
    branch_target_addr = 64'h203;
    tick();
    branch_flag = 1'b0;
    check("wait_br_pc", pc_pc, 64'h200);
    check("wait_br_no_req", {63'h0, imem_req}, 64'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = inst_of(64'h8);
    tick();
    imem_rvalid = 1'b0;
    check("stale_drop_inst", {32'h0, pc_instreg_inst}, 64'h0);
    check("stale_drop_stallreq", {63'h0, stallreq_if}, 64'h1);
    fetch(64'h200);
    tick();

    // Redirect coincident with rvalid: data dropped, REQ at target next cycle
    imem_gnt = 1'b1;
    tick();
    imem_gnt           = 1'b0;
    imem_rvalid        = 1'b1;
    imem_rdata         = inst_of(64'h204);
    branch_flag        = 1'b1;
    branch_target_addr = 64'h300;
    tick();
    imem_rvalid = 1'b0;
    branch_flag = 1'b0;
    check("rv_br_inst", {32'h0, pc_instreg_inst}, 64'h0);
    fetch(64'h300);
    tick();

    // Redirect with grant in REQ: granted fetch killed
    imem_gnt           = 1'b1;
    branch_flag        = 1'b1;
    branch_target_addr = 64'h40;
    tick();
    imem_gnt    = 1'b0;
    branch_flag = 1'b0;
    check("req_gnt_br_pc", pc_pc, 64'h40);
    check("req_gnt_br_wait", {63'h0, imem_req}, 64'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = inst_of(64'h304);
    tick();
    imem_rvalid = 1'b0;
    check("kill_drop_inst", {32'h0, pc_instreg_inst}, 64'h0);
    check("kill_drop_req", {63'h0, imem_req}, 64'h1);

    // Redirect in REQ without grant stays in REQ
    branch_flag        = 1'b1;
    branch_target_addr = 64'h7FF;
    tick();
    check("req_br_addr", imem_addr, 64'h7FC);
    check("req_br_req", {63'h0, imem_req}, 64'h1);

    // Wrap of PC at the top of the address space
    branch_target_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    branch_flag = 1'b0;
    fetch(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_pc", pc_pc, 64'h0);

    // Asynchronous reset during WAIT
    branch_flag        = 1'b1;
    branch_target_addr = 64'h500;
    tick();
    branch_flag = 1'b0;
    imem_gnt    = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("pre_rst_pc", pc_pc, 64'h500);
    rst = 1'b1;
    #1;
    check("async_rst_pc", pc_pc, 64'h0);
    check("async_rst_req", {63'h0, imem_req}, 64'h1);
    tick();
    rst = 1'b0;
    // Response to the pre-reset request is ignored
    imem_rvalid = 1'b1;
    imem_rdata  = inst_of(64'h500);
    tick();
    imem_rvalid = 1'b0;
    check("post_rst_req", {63'h0, imem_req}, 64'h1);
    check("post_rst_inst", {32'h0, pc_instreg_inst}, 64'h0);
    fetch(64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
